// File: rtl/morse_pkg.sv
// Shared definitions for the Morse receive controller.
//   state_t      : controller FSM states
//   ERR_*        : err_code values reported alongside the err pulse
//   MAX_SYMS     : longest letter (in symbols) the ROM interface can carry
//   is_decoding  : true while a finished letter is being looked up or held
package morse_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MARK,
    S_SPACE,
    S_LOOKUP,
    S_CAPTURE,
    S_OUTPUT
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_UNKNOWN  = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;
  localparam logic [1:0] ERR_OVERRUN  = 2'b11;

  localparam int unsigned MAX_SYMS = 4;

  function automatic logic is_decoding(input state_t s);
    return (s == S_LOOKUP) || (s == S_CAPTURE) || (s == S_OUTPUT);
  endfunction

endpackage

// File: rtl/morse_sym_timer.sv
// Duration counter for key-down / key-up intervals.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear (wins over en)
//   en         : count one unit this cycle
//   count      : elapsed units, saturating at all-ones
module morse_sym_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/morse_rx_ctrl.sv
// Morse receive controller: times key-down/key-up intervals, assembles a
// dot/dash pattern, presents it to an external registered ROM and hands the
// decoded character to a valid/ready consumer.
//   clk, rst_n             : clock, asynchronous active-low reset
//   key_in                 : debounced key level, 1 = key down
//   tick                   : one-cycle time-unit enable
//   in_morse_bit, morse_in : symbol count / pattern to the ROM (LOOKUP only)
//   rom_out                : ROM result, one clk after presentation, 0 = no match
//   char_out, char_valid   : decoded character, held until char_ready
//   char_ready             : consumer accept
//   err, err_code          : one-cycle error pulse and its cause
module morse_rx_ctrl
  import morse_pkg::*;
#(
  parameter int DASH_UNITS = 2,
  parameter int GAP_UNITS  = 3,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  input  logic       tick,
  output logic [2:0] in_morse_bit,
  output logic [3:0] morse_in,
  input  logic [6:0] rom_out,
  output logic [6:0] char_out,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       err,
  output logic [1:0] err_code
);

  localparam logic [CNT_W-1:0] DASH_TH  = CNT_W'(DASH_UNITS);
  // The gap closes on the tick that brings the count to GAP_UNITS.
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_UNITS - 1);
  localparam logic [2:0]       SYM_MAX  = 3'(MAX_SYMS);

  state_t           state_q, state_d;
  logic [3:0]       pattern_q, pattern_d;
  logic [2:0]       nsym_q, nsym_d;
  logic             ovf_q, ovf_d;
  logic             ignore_q, ignore_d;
  logic [6:0]       char_out_d;
  logic             char_valid_d;
  logic             err_d;
  logic [1:0]       err_code_d;
  logic             tmr_clear;
  logic             tmr_en;
  logic [CNT_W-1:0] tmr_count;
  logic             gap_done;

  assign tmr_en   = tick && ((state_q == S_MARK) || (state_q == S_SPACE));
  assign gap_done = tick && (tmr_count >= GAP_LAST);

  morse_sym_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (tmr_clear),
    .en    (tmr_en),
    .count (tmr_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pattern_q  <= '0;
      nsym_q     <= '0;
      ovf_q      <= 1'b0;
      ignore_q   <= 1'b0;
      char_out   <= '0;
      char_valid <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      nsym_q     <= nsym_d;
      ovf_q      <= ovf_d;
      ignore_q   <= ignore_d;
      char_out   <= char_out_d;
      char_valid <= char_valid_d;
      err        <= err_d;
      err_code   <= err_code_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pattern_d    = pattern_q;
    nsym_d       = nsym_q;
    ovf_d        = ovf_q;
    ignore_d     = ignore_q;
    char_out_d   = char_out;
    char_valid_d = char_valid;
    err_d        = 1'b0;
    err_code_d   = ERR_NONE;
    tmr_clear    = 1'b0;

    // A press that arrived while busy stays ignored until the key lifts.
    if (!key_in) begin
      ignore_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (key_in && !ignore_q) begin
          state_d   = S_MARK;
          tmr_clear = 1'b1;
        end
      end
      S_MARK: begin
        if (!key_in) begin
          state_d   = S_SPACE;
          tmr_clear = 1'b1;
          if (nsym_q == SYM_MAX) begin
            // Report the overflow once per letter; the letter is dropped at its gap.
            if (!ovf_q) begin
              err_d      = 1'b1;
              err_code_d = ERR_OVERFLOW;
            end
            ovf_d = 1'b1;
          end else begin
            pattern_d = {pattern_q[2:0], (tmr_count >= DASH_TH)};
            nsym_d    = nsym_q + 3'd1;
          end
        end
      end
      S_SPACE: begin
        if (key_in) begin
          state_d   = S_MARK;
          tmr_clear = 1'b1;
        end else if (gap_done) begin
          state_d = ovf_q ? S_IDLE : S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (rom_out != '0) begin
          char_out_d   = rom_out;
          char_valid_d = 1'b1;
          state_d      = S_OUTPUT;
        end else begin
          err_d      = 1'b1;
          err_code_d = ERR_UNKNOWN;
          state_d    = S_IDLE;
        end
      end
      S_OUTPUT: begin
        if (char_ready) begin
          char_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Overrun: a decode error reported in the same cycle takes the pulse,
    // but the press is still marked as ignored.
    if (is_decoding(state_q) && key_in && !ignore_q) begin
      ignore_d = 1'b1;
      if (!err_d) begin
        err_d      = 1'b1;
        err_code_d = ERR_OVERRUN;
      end
    end

    if (state_d == S_IDLE) begin
      pattern_d = '0;
      nsym_d    = '0;
      ovf_d     = 1'b0;
    end
  end

  always_comb begin
    in_morse_bit = '0;
    morse_in     = '0;
    if (state_q == S_LOOKUP) begin
      in_morse_bit = nsym_q;
      morse_in     = pattern_q;
    end
  end

endmodule
